// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if
//   Bundles the FIFO read side and the packed-word stream of fifo_rd_packer.
//   Signal names keep the packer's i_/o_ view so they read the same at both ends.
//
//   master : the packer (pops the FIFO, drives the packed stream)
//   slave  : the environment (FIFO read port, flush source, downstream sink)
//
//   i_fifo_empty  FIFO o_empty
//   o_fifo_r_en   FIFO r_en, one pop per high cycle
//   i_fifo_data   FIFO o_data, valid one cycle after a pop
//   i_flush       single-cycle request to emit any partial word
//   o_valid       packed word available
//   i_ready       downstream accepts the word
//   o_data        packed word, lane k at [k*P_DATA_W +: P_DATA_W]
//   o_bcnt        number of valid lanes in o_data
interface fifo_rd_packer_if #(
    parameter int P_DATA_W = 8,
    parameter int P_RATIO  = 4,
    parameter int P_CNT_W  = $clog2(P_RATIO + 1)
);
    logic                          i_fifo_empty;
    logic                          o_fifo_r_en;
    logic [P_DATA_W-1:0]           i_fifo_data;
    logic                          i_flush;
    logic                          o_valid;
    logic                          i_ready;
    logic [P_DATA_W*P_RATIO-1:0]   o_data;
    logic [P_CNT_W-1:0]            o_bcnt;

    modport master (
        input  i_fifo_empty, i_fifo_data, i_flush, i_ready,
        output o_fifo_r_en, o_valid, o_data, o_bcnt
    );

    modport slave (
        output i_fifo_empty, i_fifo_data, i_flush, i_ready,
        input  o_fifo_r_en, o_valid, o_data, o_bcnt
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer of the async FIFO, in the FIFO read clock domain.
//   Pops P_DATA_W-bit entries (1-cycle read latency) and packs P_RATIO of them
//   little-endian into one word presented on a valid/ready stream. A flush
//   pulse forces out a partial word; o_bcnt gives the number of valid lanes.
//
//   clk    FIFO read clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_rd_packer_if.master (FIFO read port, flush, packed stream)
module fifo_rd_packer #(
    parameter int P_DATA_W = 8,
    parameter int P_RATIO  = 4,
    parameter int P_CNT_W  = $clog2(P_RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_rd_packer_if.master bus
);

    localparam int                 IDX_W   = (P_RATIO > 1) ? $clog2(P_RATIO) : 1;
    localparam logic [P_CNT_W-1:0] RATIO_C = P_CNT_W'(P_RATIO);
    localparam logic [P_CNT_W-1:0] ONE_C   = P_CNT_W'(1);

    typedef enum logic {S_FILL, S_OUT} state_t;

    state_t                           state, state_nxt;
    logic [P_CNT_W-1:0]               cnt, cnt_nxt, cnt_inc;
    logic                             pend;
    logic                             flush_req, flush_req_nxt;
    logic                             valid, valid_nxt;
    logic [P_CNT_W-1:0]               bcnt, bcnt_nxt;
    logic [P_RATIO-1:0][P_DATA_W-1:0] lanes, lanes_nxt;
    logic [P_CNT_W:0]                 occ;
    logic                             r_en;

    // Lanes already captured plus the one in flight must leave room for another pop.
    // rst_n gating keeps the FIFO untouched while reset is held.
    assign occ     = {1'b0, cnt} + {{P_CNT_W{1'b0}}, pend};
    assign cnt_inc = cnt + ONE_C;
    assign r_en    = rst_n & (state == S_FILL) & ~bus.i_fifo_empty & ~flush_req
                   & (occ < {1'b0, RATIO_C});

    assign bus.o_fifo_r_en = r_en;
    assign bus.o_valid     = valid;
    assign bus.o_data      = lanes;
    assign bus.o_bcnt      = bcnt;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lanes_nxt     = lanes;
        valid_nxt     = valid;
        bcnt_nxt      = bcnt;
        flush_req_nxt = flush_req | bus.i_flush;
        case (state)
            S_FILL: begin
                if (pend) begin
                    // In-flight entry is always captured before a flush is looked at.
                    lanes_nxt[cnt[IDX_W-1:0]] = bus.i_fifo_data;
                    cnt_nxt                   = cnt_inc;
                    if (cnt_inc == RATIO_C) begin
                        state_nxt = S_OUT;
                        valid_nxt = 1'b1;
                        bcnt_nxt  = RATIO_C;
                    end
                end else if (flush_req) begin
                    // Consume the flush; a fresh pulse this cycle re-arms it.
                    flush_req_nxt = bus.i_flush;
                    if (cnt != '0) begin
                        state_nxt = S_OUT;
                        valid_nxt = 1'b1;
                        bcnt_nxt  = cnt;
                    end
                end
            end
            S_OUT: begin
                // valid is always set here, so i_ready alone completes the beat.
                if (bus.i_ready) begin
                    state_nxt = S_FILL;
                    valid_nxt = 1'b0;
                    lanes_nxt = '0;
                    bcnt_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            cnt       <= '0;
            pend      <= 1'b0;
            flush_req <= 1'b0;
            valid     <= 1'b0;
            bcnt      <= '0;
            lanes     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend      <= r_en;
            flush_req <= flush_req_nxt;
            valid     <= valid_nxt;
            bcnt      <= bcnt_nxt;
            lanes     <= lanes_nxt;
        end
    end

endmodule
